// File: rtl/contador_pkg.sv
// Shared types and default sizing for the tick counter controller.
package contador_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    RUN   = 2'b01,
    PAUSE = 2'b10,
    DONE  = 2'b11
  } estado_t;

  localparam int DEF_WIDTH    = 3;
  localparam int DEF_PRESCALE = 4;

endpackage

// File: rtl/sincronizador_borda.sv
// Brings an asynchronous push-button into the clk domain and turns each rising edge into a one-cycle pulse.
module sincronizador_borda (
  input  logic clk,
  input  logic reset,
  input  logic in,
  output logic pulse
);

  logic sync1;
  logic sync2;
  logic prev;

  // Two-flop synchronizer plus previous-sample register; all preset to 1 so a button held through reset gives no edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
      prev  <= 1'b1;
    end else begin
      sync1 <= in;
      sync2 <= sync1;
      prev  <= sync2;
    end
  end

  assign pulse = sync2 & ~prev;

endmodule

// File: rtl/controlador_contador.sv
// Start/stop/pause counter driven either by a free-running prescaler or by debounced push-button clicks.
module controlador_contador
  import contador_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int PRESCALE = DEF_PRESCALE
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             click,
  input  logic             start,
  input  logic             stop,
  input  logic             auto,
  input  logic [WIDTH-1:0] limite,
  output logic [WIDTH-1:0] contagem,
  output logic [1:0]       estado,
  output logic             done,
  output logic             running
);

  localparam int PW = $clog2(PRESCALE);
  localparam logic [PW-1:0] PRESC_LAST = PW'(PRESCALE - 1);

  estado_t          state;
  estado_t          state_next;
  logic [WIDTH-1:0] cont_next;
  logic [PW-1:0]    presc;
  logic [PW-1:0]    presc_next;
  logic             presc_term;
  logic             click_pulse;
  logic             tick;

  sincronizador_borda u_sync (
    .clk   (clk),
    .reset (reset),
    .in    (click),
    .pulse (click_pulse)
  );

  assign presc_term = (presc == PRESC_LAST);
  assign tick       = auto ? presc_term : click_pulse;

  // Next state, next count and next prescaler value; stop is tested before start so it always wins.
  always_comb begin
    state_next = state;
    cont_next  = contagem;
    presc_next = presc;
    case (state)
      IDLE: begin
        cont_next  = '0;
        presc_next = '0;
        if (!stop && start) begin
          state_next = RUN;
        end
      end
      RUN: begin
        if (auto) begin
          presc_next = presc_term ? '0 : presc + PW'(1);
        end else begin
          presc_next = '0;
        end
        if (stop) begin
          state_next = PAUSE;
        end else if (tick) begin
          if (contagem >= limite) begin
            state_next = DONE;
          end else begin
            cont_next = contagem + WIDTH'(1);
          end
        end
      end
      PAUSE: begin
        if (!auto) begin
          presc_next = '0;
        end
        if (stop) begin
          state_next = IDLE;
          cont_next  = '0;
          presc_next = '0;
        end else if (start) begin
          state_next = RUN;
        end
      end
      DONE: begin
        presc_next = '0;
        if (stop) begin
          state_next = IDLE;
          cont_next  = '0;
        end else if (start) begin
          state_next = RUN;
          cont_next  = '0;
        end
      end
      default: begin
        state_next = IDLE;
        cont_next  = '0;
        presc_next = '0;
      end
    endcase
  end

  // State, count and prescaler registers with synchronous reset taking priority over every input.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      contagem <= '0;
      presc    <= '0;
    end else begin
      state    <= state_next;
      contagem <= cont_next;
      presc    <= presc_next;
    end
  end

  assign estado  = state;
  assign done    = (state == DONE);
  assign running = (state == RUN);

endmodule

// File: tb/tb_controlador_contador.sv
// Directed bench for controlador_contador with default WIDTH=3, PRESCALE=4.
module tb_controlador_contador;
  import contador_pkg::*;

  logic       clk;
  logic       reset;
  logic       click;
  logic       start;
  logic       stop;
  logic       auto;
  logic [2:0] limite;
  logic [2:0] contagem;
  logic [1:0] estado;
  logic       done;
  logic       running;

  int checks = 0;
  int errors = 0;

  controlador_contador dut (
    .clk      (clk),
    .reset    (reset),
    .click    (click),
    .start    (start),
    .stop     (stop),
    .auto     (auto),
    .limite   (limite),
    .contagem (contagem),
    .estado   (estado),
    .done     (done),
    .running  (running)
  );

  // 10-unit clock; inputs change and outputs are sampled on the falling edge.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Guard against a stuck run.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic applyStimulus(input logic s, input logic p, input logic a,
                               input logic c, input logic [2:0] l);
    start  = s;
    stop   = p;
    auto   = a;
    click  = c;
    limite = l;
  endtask

  task automatic checkOutput(input string tag, input logic [2:0] exp_c, input estado_t exp_s);
    logic [6:0] obs;
    logic [6:0] exp_v;
    obs   = {contagem, estado, done, running};
    exp_v = {exp_c, exp_s, (exp_s == DONE), (exp_s == RUN)};
    checks++;
    assert (obs === exp_v)
    else begin
      errors++;
      $error("[TB] FAIL %s observed cont=%0d st=%b done=%b run=%b expected cont=%0d st=%b done=%b run=%b",
             tag, obs[6:4], obs[3:2], obs[1], obs[0], exp_v[6:4], exp_v[3:2], exp_v[1], exp_v[0]);
    end
  endtask

  task automatic clickFor(input int width);
    click = 1'b1;
    cycles(width);
    click = 1'b0;
    cycles(4);
  endtask

  initial begin
    reset = 1'b1;
    applyStimulus(0, 0, 0, 0, 3'd0);
    @(negedge clk);
    cycles(2);
    reset = 1'b0;
    checkOutput("reset", 3'd0, IDLE);

    // Auto mode, limite 5: one count every 4 clocks, DONE 4 clocks after reaching 5.
    $display("[TB] auto count to 5");
    applyStimulus(1, 0, 1, 0, 3'd5);
    cycles(1);
    start = 1'b0;
    checkOutput("auto_start", 3'd0, RUN);
    cycles(3);
    checkOutput("auto_pre3", 3'd0, RUN);
    cycles(1);
    checkOutput("auto_first", 3'd1, RUN);
    cycles(16);
    checkOutput("auto_five", 3'd5, RUN);
    cycles(3);
    checkOutput("auto_five_hold", 3'd5, RUN);
    cycles(1);
    checkOutput("auto_done", 3'd5, DONE);
    cycles(5);
    checkOutput("auto_done_held", 3'd5, DONE);

    // start+stop together in DONE and IDLE behave as stop.
    applyStimulus(1, 1, 1, 0, 3'd5);
    cycles(1);
    checkOutput("both_in_done", 3'd0, IDLE);
    cycles(1);
    checkOutput("both_in_idle", 3'd0, IDLE);

    // Manual clicks: one long press is one count, visible on the 3rd edge.
    $display("[TB] manual clicks");
    applyStimulus(1, 0, 0, 0, 3'd7);
    cycles(1);
    start = 1'b0;
    checkOutput("man_start", 3'd0, RUN);
    click = 1'b1;
    cycles(2);
    checkOutput("click_edge2", 3'd0, RUN);
    cycles(1);
    checkOutput("click_edge3", 3'd1, RUN);
    cycles(7);
    checkOutput("click_long", 3'd1, RUN);
    click = 1'b0;
    cycles(4);
    clickFor(3);
    clickFor(3);
    checkOutput("click_three", 3'd3, RUN);

    // Pause, ignored click, resume, then double stop to IDLE.
    stop = 1'b1;
    cycles(1);
    stop = 1'b0;
    checkOutput("pause", 3'd3, PAUSE);
    clickFor(3);
    checkOutput("pause_click", 3'd3, PAUSE);
    start = 1'b1;
    cycles(1);
    start = 1'b0;
    checkOutput("resume", 3'd3, RUN);
    stop = 1'b1;
    cycles(1);
    checkOutput("stop_once", 3'd3, PAUSE);
    cycles(1);
    stop = 1'b0;
    checkOutput("stop_twice", 3'd0, IDLE);

    // start+stop in RUN coincident with a click tick: PAUSE, tick dropped.
    applyStimulus(1, 0, 0, 0, 3'd7);
    cycles(1);
    start = 1'b0;
    click = 1'b1;
    cycles(2);
    start = 1'b1;
    stop  = 1'b1;
    cycles(1);
    applyStimulus(0, 0, 0, 0, 3'd7);
    checkOutput("both_in_run", 3'd0, PAUSE);
    cycles(4);
    checkOutput("both_in_run_hold", 3'd0, PAUSE);
    stop = 1'b1;
    cycles(1);
    stop = 1'b0;
    checkOutput("pause_to_idle", 3'd0, IDLE);

    // limite 0: first tick goes to DONE with 0.
    $display("[TB] limite boundaries");
    applyStimulus(1, 0, 1, 0, 3'd0);
    cycles(1);
    start = 1'b0;
    cycles(3);
    checkOutput("lim0_wait", 3'd0, RUN);
    cycles(1);
    checkOutput("lim0_done", 3'd0, DONE);

    // limite 7: stop at 7, never wrap.
    applyStimulus(1, 0, 1, 0, 3'd7);
    cycles(1);
    start = 1'b0;
    checkOutput("restart_from_done", 3'd0, RUN);
    cycles(28);
    checkOutput("lim7_seven", 3'd7, RUN);
    cycles(4);
    checkOutput("lim7_done", 3'd7, DONE);
    cycles(8);
    checkOutput("lim7_nowrap", 3'd7, DONE);

    // Lowering limite below the count causes DONE on the next tick.
    applyStimulus(0, 1, 1, 0, 3'd7);
    cycles(1);
    applyStimulus(1, 0, 1, 0, 3'd7);
    cycles(1);
    start = 1'b0;
    cycles(16);
    checkOutput("lower_at4", 3'd4, RUN);
    limite = 3'd2;
    cycles(3);
    checkOutput("lower_wait", 3'd4, RUN);
    cycles(1);
    checkOutput("lower_done", 3'd4, DONE);

    // Reset mid-RUN at 4 aborts; prescaler restarts from 0.
    $display("[TB] reset cases");
    applyStimulus(1, 0, 1, 0, 3'd7);
    cycles(1);
    start = 1'b0;
    cycles(16);
    checkOutput("pre_reset", 3'd4, RUN);
    reset = 1'b1;
    cycles(1);
    reset = 1'b0;
    checkOutput("mid_run_reset", 3'd0, IDLE);
    start = 1'b1;
    cycles(1);
    start = 1'b0;
    cycles(3);
    checkOutput("post_reset_pre", 3'd0, RUN);
    cycles(1);
    checkOutput("post_reset_tick", 3'd1, RUN);

    // Click held through reset release gives no count.
    applyStimulus(0, 0, 0, 1, 3'd7);
    reset = 1'b1;
    cycles(2);
    reset = 1'b0;
    start = 1'b1;
    cycles(1);
    start = 1'b0;
    cycles(6);
    checkOutput("click_thru_reset", 3'd0, RUN);
    click = 1'b0;
    cycles(4);
    checkOutput("click_thru_release", 3'd0, RUN);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
